// File: rtl/lpif_pkg.sv
// Shared LPIF definitions: link-state encodings, stall FSM states and the
// flush-state classifier used by the transmit buffer.
package lpif_pkg;

    typedef enum logic [3:0] {
        ST_RESET     = 4'h0,
        ST_ACTIVE    = 4'h1,
        ST_L1        = 4'h4,
        ST_LINKRESET = 4'h9,
        ST_RETRAIN   = 4'hB,
        ST_DISABLED  = 4'hC
    } lpif_state_e;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        STALLED
    } stall_fsm_e;

    function automatic logic is_flush_state(input logic [3:0] st);
        return (st == ST_RESET) || (st == ST_LINKRESET) || (st == ST_DISABLED);
    endfunction

endpackage

// File: rtl/lpif_tx_fifo.sv
// Beat FIFO with extra-bit pointers and a synchronous clear; head entry is
// presented combinationally on rdata.
module lpif_tx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         full;
    logic         do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/lpif_tx_buffer.sv
// LPIF transmit buffer: FIFO plus a registered offer stage with irdy/trdy,
// link-state gating/flush and the stall_req/stall_ack handshake.
module lpif_tx_buffer #(
    parameter int NBYTES = 8,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NBYTES*8-1:0]          s_data,
    input  logic [NBYTES-1:0]            s_valid,
    input  logic                         s_push,
    output logic                         s_ready,
    output logic [NBYTES*8-1:0]          data,
    output logic [NBYTES-1:0]            valid,
    output logic                         irdy,
    input  logic                         trdy,
    input  logic [3:0]                   state_sts,
    input  logic                         stall_req,
    output logic                         stall_ack,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [31:0]                  tx_beats
);
    import lpif_pkg::*;

    localparam int LW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [NBYTES-1:0]   valid;
        logic [NBYTES*8-1:0] data;
    } beat_t;

    beat_t       s_beat, head_beat, next_beat, out_q;
    logic        fifo_empty;
    logic [AW:0] fifo_count;
    logic        flush, accept, wr, have_beat, offer_ok, load, fifo_push, fifo_pop;
    stall_fsm_e  fsm_q, fsm_d;
    logic [31:0] tx_cnt;

    assign s_beat  = {s_valid, s_data};
    assign flush   = is_flush_state(state_sts);
    assign accept  = irdy && trdy;
    assign level   = LW'(fifo_count) + LW'(irdy);
    assign s_ready = (level < LW'(DEPTH)) && !flush;
    assign wr      = s_push && s_ready;

    // A beat pushed into an empty FIFO goes straight to the offer register,
    // giving one-cycle push-to-irdy latency.
    assign have_beat = !fifo_empty || wr;
    assign offer_ok  = (state_sts == ST_ACTIVE) && !stall_req;
    assign load      = offer_ok && have_beat && (!irdy || trdy);
    assign next_beat = fifo_empty ? s_beat : head_beat;
    assign fifo_push = wr && !(load && fifo_empty);
    assign fifo_pop  = load && !fifo_empty;

    lpif_tx_fifo #(
        .W     (NBYTES*8 + NBYTES),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .push  (fifo_push),
        .wdata (s_beat),
        .pop   (fifo_pop),
        .rdata (head_beat),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Offer register: payload is zeroed whenever nothing is offered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irdy  <= 1'b0;
            out_q <= '0;
        end else if (flush) begin
            irdy  <= 1'b0;
            out_q <= '0;
        end else if (load) begin
            irdy  <= 1'b1;
            out_q <= next_beat;
        end else if (accept) begin
            irdy  <= 1'b0;
            out_q <= '0;
        end
    end

    assign data  = out_q.data;
    assign valid = out_q.valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) fsm_q <= RUN;
        else        fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d     = fsm_q;
        stall_ack = 1'b0;
        unique case (fsm_q)
            RUN:     if (stall_req) fsm_d = (irdy && !trdy) ? DRAIN : STALLED;
            DRAIN: begin
                if (!stall_req)         fsm_d = RUN;
                else if (!irdy || trdy) fsm_d = STALLED;
            end
            STALLED: begin
                stall_ack = 1'b1;
                if (!stall_req) fsm_d = RUN;
            end
            default: fsm_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      tx_cnt <= '0;
        else if (accept) tx_cnt <= tx_cnt + 32'd1;
    end

    assign tx_beats = tx_cnt;

endmodule

// File: tb/tb_lpif_tx_buffer.sv
// Self-checking bench: scenario tasks plus a queue-based scoreboard for the
// 8-byte/4-deep instance, and a 16-byte/8-deep instance for wrap and reset.
module tb_lpif_tx_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance A: NBYTES=8, DEPTH=4
    logic        rst_n;
    logic [63:0] a_s_data, a_data;
    logic [7:0]  a_s_valid, a_valid;
    logic        a_s_push, a_s_ready, a_irdy, a_trdy, a_stall_req, a_stall_ack;
    logic [3:0]  a_state;
    logic [2:0]  a_level;
    logic [31:0] a_tx;

    // instance B: NBYTES=16, DEPTH=8
    logic         b_rst_n;
    logic [127:0] b_s_data, b_data;
    logic [15:0]  b_s_valid, b_valid;
    logic         b_s_push, b_s_ready, b_irdy, b_trdy, b_stall_req, b_stall_ack;
    logic [3:0]   b_state;
    logic [3:0]   b_level;
    logic [31:0]  b_tx;

    int n_checks = 0;
    int n_fails  = 0;

    logic [71:0]  beat_q[$];
    int unsigned  exp_tx;
    bit           hold;
    logic [71:0]  prev_beat;
    logic [143:0] bq[$];
    int unsigned  exp_b_tx;

    lpif_tx_buffer #(.NBYTES(8), .DEPTH(4)) dut_a (
        .clk(clk), .reset(rst_n), .s_data(a_s_data), .s_valid(a_s_valid),
        .s_push(a_s_push), .s_ready(a_s_ready), .data(a_data), .valid(a_valid),
        .irdy(a_irdy), .trdy(a_trdy), .state_sts(a_state), .stall_req(a_stall_req),
        .stall_ack(a_stall_ack), .level(a_level), .tx_beats(a_tx)
    );

    lpif_tx_buffer #(.NBYTES(16), .DEPTH(8)) dut_b (
        .clk(clk), .reset(b_rst_n), .s_data(b_s_data), .s_valid(b_s_valid),
        .s_push(b_s_push), .s_ready(b_s_ready), .data(b_data), .valid(b_valid),
        .irdy(b_irdy), .trdy(b_trdy), .state_sts(b_state), .stall_req(b_stall_req),
        .stall_ack(b_stall_ack), .level(b_level), .tx_beats(b_tx)
    );

    function automatic bit is_fl(input logic [3:0] s);
        return (s == 4'h0) || (s == 4'h9) || (s == 4'hC);
    endfunction

    function automatic logic [71:0] rnd_beat();
        logic [7:0] v;
        v = 8'($urandom_range(1, 255));
        return {v, $urandom(), $urandom()};
    endfunction

    function automatic logic [143:0] rnd_beat_b();
        logic [15:0] v;
        v = 16'($urandom_range(1, 65535));
        return {v, $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Scoreboard step for instance A: checks current outputs against the model,
    // applies this cycle's accept/push/flush to the model, advances one clock.
    task automatic tick();
        logic [71:0] cur, exp_b;
        bit fl;
        #2;
        cur = {a_valid, a_data};
        fl  = is_fl(a_state);
        n_checks++;
        if (a_level !== 3'(beat_q.size())) begin
            n_fails++; $display("FAIL level: got %0d expected %0d", a_level, beat_q.size());
        end
        n_checks++;
        if (a_s_ready !== (beat_q.size() < 4 && !fl)) begin
            n_fails++; $display("FAIL s_ready: got %0b expected %0b", a_s_ready, (beat_q.size() < 4 && !fl));
        end
        n_checks++;
        if (a_tx !== exp_tx) begin
            n_fails++; $display("FAIL tx_beats: got %0d expected %0d", a_tx, exp_tx);
        end
        if (!a_irdy) begin
            n_checks++;
            if (cur !== '0) begin
                n_fails++; $display("FAIL idle_zero: got %h expected 0", cur);
            end
        end
        if (hold) begin
            n_checks++;
            if (a_irdy !== 1'b1 || cur !== prev_beat) begin
                n_fails++; $display("FAIL hold: got irdy=%b %h expected irdy=1 %h", a_irdy, cur, prev_beat);
            end
        end
        if (a_irdy && a_trdy) begin
            n_checks++;
            if (beat_q.size() == 0) begin
                n_fails++; $display("FAIL order: got %h expected no beat", cur);
            end else begin
                exp_b = beat_q.pop_front();
                if (cur !== exp_b) begin
                    n_fails++; $display("FAIL order: got %h expected %h", cur, exp_b);
                end
            end
            exp_tx++;
        end
        if (a_s_push && a_s_ready) beat_q.push_back({a_s_valid, a_s_data});
        if (fl) beat_q.delete();
        hold      = a_irdy && !a_trdy && !fl;
        prev_beat = cur;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b();
        logic [143:0] exp_b;
        #2;
        if (b_irdy && b_trdy) begin
            n_checks++;
            exp_b = (bq.size() != 0) ? bq.pop_front() : '0;
            if ({b_valid, b_data} !== exp_b) begin
                n_fails++; $display("FAIL b_order: got %h expected %h", {b_valid, b_data}, exp_b);
            end
            exp_b_tx++;
        end
        if (b_s_push && b_s_ready) bq.push_back({b_s_valid, b_s_data});
        @(posedge clk);
        #1;
        n_checks++;
        if (b_tx !== exp_b_tx) begin
            n_fails++; $display("FAIL b_tx_beats: got %h expected %h", b_tx, exp_b_tx);
        end
    endtask

    task automatic push_a(input int n);
        for (int i = 0; i < n; i++) begin
            a_s_push = 1'b1;
            {a_s_valid, a_s_data} = rnd_beat();
            tick();
        end
        a_s_push = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; b_rst_n = 1'b0;
        a_s_push = 0; a_s_data = '0; a_s_valid = '0; a_trdy = 0; a_state = 4'h1; a_stall_req = 0;
        b_s_push = 0; b_s_data = '0; b_s_valid = '0; b_trdy = 0; b_state = 4'h1; b_stall_req = 0;
        #1;
        n_checks++;
        if (a_irdy !== 1'b0 || a_data !== '0 || a_valid !== '0 || a_stall_ack !== 1'b0 ||
            a_level !== 3'd0 || a_tx !== 32'd0 || a_s_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL reset: got irdy=%b data=%h valid=%h ack=%b level=%0d tx=%0d s_ready=%b expected 0/0/0/0/0/0/1",
                     a_irdy, a_data, a_valid, a_stall_ack, a_level, a_tx, a_s_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; b_rst_n = 1'b1;
        beat_q.delete(); exp_tx = 0; hold = 0; prev_beat = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        a_trdy = 1; a_state = 4'h1;
        for (int i = 0; i < 6; i++) begin
            a_s_push = 1'b1;
            {a_s_valid, a_s_data} = rnd_beat();
            tick();
            n_checks++;
            if (a_irdy !== 1'b1 || a_s_ready !== 1'b1) begin
                n_fails++; $display("FAIL b2b_flow: got irdy=%b s_ready=%b expected 1/1", a_irdy, a_s_ready);
            end
        end
        a_s_push = 1'b0;
        tick(); tick();
        n_checks++;
        if (a_tx !== 32'd6 || a_irdy !== 1'b0 || a_level !== 3'd0) begin
            n_fails++; $display("FAIL b2b_done: got tx=%0d irdy=%b level=%0d expected 6/0/0", a_tx, a_irdy, a_level);
        end
    endtask

    task automatic test_backpressure();
        logic [71:0] snap;
        a_trdy = 0;
        push_a(4);
        n_checks++;
        if (a_level !== 3'd4 || a_s_ready !== 1'b0) begin
            n_fails++; $display("FAIL full: got level=%0d s_ready=%b expected 4/0", a_level, a_s_ready);
        end
        snap = {a_valid, a_data};
        repeat (3) tick();
        n_checks++;
        if (a_irdy !== 1'b1 || {a_valid, a_data} !== snap) begin
            n_fails++; $display("FAIL stable: got %h expected %h", {a_valid, a_data}, snap);
        end
        a_trdy = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (a_level !== 3'(3 - i)) begin
                n_fails++; $display("FAIL drain_level: got %0d expected %0d", a_level, 3 - i);
            end
        end
    endtask

    task automatic test_stall_pending();
        a_trdy = 0;
        push_a(3);
        a_stall_req = 1;
        repeat (2) begin
            tick();
            n_checks++;
            if (a_stall_ack !== 1'b0 || a_irdy !== 1'b1) begin
                n_fails++; $display("FAIL drain_hold: got ack=%b irdy=%b expected 0/1", a_stall_ack, a_irdy);
            end
        end
        a_trdy = 1;
        repeat (2) begin
            tick();
            n_checks++;
            if (a_stall_ack !== 1'b1 || a_irdy !== 1'b0 || a_level !== 3'd2) begin
                n_fails++; $display("FAIL stalled: got ack=%b irdy=%b level=%0d expected 1/0/2", a_stall_ack, a_irdy, a_level);
            end
        end
        a_stall_req = 0;
        tick();
        n_checks++;
        if (a_stall_ack !== 1'b0 || a_irdy !== 1'b1) begin
            n_fails++; $display("FAIL resume: got ack=%b irdy=%b expected 0/1", a_stall_ack, a_irdy);
        end
        tick(); tick();
        n_checks++;
        if (a_level !== 3'd0 || a_irdy !== 1'b0) begin
            n_fails++; $display("FAIL resume_done: got level=%0d irdy=%b expected 0/0", a_level, a_irdy);
        end
    endtask

    task automatic test_stall_idle();
        a_trdy = 1; a_stall_req = 1;
        tick();
        n_checks++;
        if (a_stall_ack !== 1'b1 || a_irdy !== 1'b0) begin
            n_fails++; $display("FAIL idle_stall: got ack=%b irdy=%b expected 1/0", a_stall_ack, a_irdy);
        end
        push_a(1);
        n_checks++;
        if (a_stall_ack !== 1'b1 || a_irdy !== 1'b0 || a_level !== 3'd1) begin
            n_fails++; $display("FAIL stall_push: got ack=%b irdy=%b level=%0d expected 1/0/1", a_stall_ack, a_irdy, a_level);
        end
        a_stall_req = 0;
        tick();
        n_checks++;
        if (a_stall_ack !== 1'b0 || a_irdy !== 1'b1) begin
            n_fails++; $display("FAIL unstall: got ack=%b irdy=%b expected 0/1", a_stall_ack, a_irdy);
        end
        // stall request withdrawn while draining: no acknowledge
        a_trdy = 0;
        tick();
        push_a(1);
        a_stall_req = 1;
        tick();
        a_stall_req = 0;
        tick();
        n_checks++;
        if (a_stall_ack !== 1'b0 || a_irdy !== 1'b1) begin
            n_fails++; $display("FAIL drain_cancel: got ack=%b irdy=%b expected 0/1", a_stall_ack, a_irdy);
        end
        a_trdy = 1;
        repeat (3) tick();
    endtask

    task automatic test_flush();
        a_trdy = 0;
        push_a(3);
        a_state = 4'h9;
        tick();
        n_checks++;
        if (a_level !== 3'd0 || a_irdy !== 1'b0 || a_s_ready !== 1'b0 || a_data !== '0) begin
            n_fails++; $display("FAIL flush: got level=%0d irdy=%b s_ready=%b data=%h expected 0/0/0/0",
                                a_level, a_irdy, a_s_ready, a_data);
        end
        tick();
        a_state = 4'h1; a_trdy = 1;
        tick();
        n_checks++;
        if (a_s_ready !== 1'b1 || a_level !== 3'd0 || a_irdy !== 1'b0) begin
            n_fails++; $display("FAIL post_flush: got s_ready=%b level=%0d irdy=%b expected 1/0/0", a_s_ready, a_level, a_irdy);
        end
        tick();
        n_checks++;
        if (a_irdy !== 1'b0) begin
            n_fails++; $display("FAIL stale_beat: got irdy=%b expected 0", a_irdy);
        end
    endtask

    task automatic test_retrain();
        a_trdy = 0; a_state = 4'hB;
        push_a(2);
        tick(); tick();
        n_checks++;
        if (a_irdy !== 1'b0 || a_level !== 3'd2) begin
            n_fails++; $display("FAIL retrain_hold: got irdy=%b level=%0d expected 0/2", a_irdy, a_level);
        end
        a_state = 4'h1; a_trdy = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (a_irdy !== (i < 2)) begin
                n_fails++; $display("FAIL retrain_send: got irdy=%b expected %0b", a_irdy, (i < 2));
            end
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                r = $urandom_range(0, 9);
                a_state = (r < 5) ? 4'h1 : (r < 7) ? 4'hB : (r < 8) ? 4'h4 : (r < 9) ? 4'h9 : 4'hC;
            end
            if ($urandom_range(0, 99) < 8) a_stall_req = ~a_stall_req;
            a_trdy   = ($urandom_range(0, 99) < 65);
            a_s_push = ($urandom_range(0, 99) < 60);
            {a_s_valid, a_s_data} = rnd_beat();
            tick();
        end
        a_state = 4'h1; a_stall_req = 0; a_trdy = 1; a_s_push = 0;
        repeat (8) tick();
        n_checks++;
        if (a_level !== 3'd0 || a_irdy !== 1'b0) begin
            n_fails++; $display("FAIL random_drain: got level=%0d irdy=%b expected 0/0", a_level, a_irdy);
        end
    endtask

    task automatic test_wrap_and_reset();
        b_state = 4'h1; b_trdy = 1; b_stall_req = 0; b_s_push = 0;
        force dut_b.tx_cnt = 32'hFFFF_FFFE;
        @(posedge clk); #1;
        release dut_b.tx_cnt;
        exp_b_tx = 32'hFFFF_FFFE;
        bq.delete();
        for (int i = 0; i < 5; i++) begin
            b_s_push = (i < 3);
            {b_s_valid, b_s_data} = rnd_beat_b();
            step_b();
        end
        n_checks++;
        if (b_tx !== 32'd1) begin
            n_fails++; $display("FAIL wrap: got %h expected 00000001", b_tx);
        end
        b_trdy = 0;
        for (int i = 0; i < 2; i++) begin
            b_s_push = 1;
            {b_s_valid, b_s_data} = rnd_beat_b();
            step_b();
        end
        b_s_push = 0;
        n_checks++;
        if (b_irdy !== 1'b1 || b_level !== 4'd2) begin
            n_fails++; $display("FAIL b_pending: got irdy=%b level=%0d expected 1/2", b_irdy, b_level);
        end
        #2 b_rst_n = 1'b0;
        #1;
        n_checks++;
        if (b_irdy !== 1'b0 || b_data !== '0 || b_valid !== '0 || b_stall_ack !== 1'b0 ||
            b_level !== 4'd0 || b_tx !== 32'd0 || b_s_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL async_reset: got irdy=%b data=%h valid=%h ack=%b level=%0d tx=%0d s_ready=%b expected 0/0/0/0/0/0/1",
                     b_irdy, b_data, b_valid, b_stall_ack, b_level, b_tx, b_s_ready);
        end
        #1 b_rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_stall_pending();
        test_stall_idle();
        test_flush();
        test_retrain();
        test_random();
        test_wrap_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
